shift_rows_stream: RTL
======================

Name: shift_rows_stream

Overview:
- Byte-serial forward AES ShiftRows for the optimised encrypt datapath; the transmit-direction counterpart of the decrypt-side inverse ShiftRows.
- Accepts 16-byte states in column-major order (index k = 4c + r), one byte per handshake.
- Emits each permuted state in the same order: out[r][c] = in[r][(c + r) mod 4].
- Uses a 2-bank ping-pong buffer with valid/ready handshakes, so sustained throughput is 1 byte/cycle and a stalled downstream stage is tolerated.

Parameters:
- DATA_W, 8: width of each state element in bits.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in_valid  input  1  in_byte is valid this cycle.
- in_byte  input  DATA_W  input state byte, column-major order.
- in_ready  output  1  block can accept a byte this cycle.
- out_valid  output  1  out_byte holds a valid permuted byte.
- out_byte  output  DATA_W  output state byte, column-major order.
- out_ready  input  1  downstream accepts out_byte this cycle.
- out_last  output  1  high with out_valid on byte 15 of each output block.

Behaviour:
- Reset values: in_ready=1 after deassert; out_valid=0; out_byte=0; out_last=0.
- Reset behaviour: wr_cnt=0, rd_cnt=0, wr_bank=0, rd_bank=0; both bank full flags cleared. The bank contents need not be reset.
- Reset mid-block: any partially written or partially read block is discarded. No byte of it appears after reset.
- Storage: two banks of 16 x DATA_W, each with a full flag.
- Write side:
  - in_ready = ~full[wr_bank].
  - On in_valid & in_ready: bank[wr_bank][wr_cnt] <= in_byte; wr_cnt increments.
  - When wr_cnt=15 is written: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Read address: for output index k = 4c + r, the address is 4*((c + r) & 3) + r.
  - k = 0..15 maps to 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
- Read side FSM, two states:
  - IDLE: out register empty or holding the last byte.
  - STREAM: bank[rd_bank] is full and being drained.
- Output register advance:
  - The register loads when (~out_valid | out_ready) & full[rd_bank].
  - On load: out_byte <= bank[rd_bank][addr(rd_cnt)]; out_last <= (rd_cnt==15); rd_cnt increments.
  - Loading rd_cnt=15: full[rd_bank] <= 0; rd_bank toggles; rd_cnt wraps to 0.
  - out_valid clears when out_ready=1 and no new load occurs.
- Latency: out_valid rises on the edge after the edge that accepted byte 15. The first output byte is in[0][0].
- Simultaneous events:
  - A write completing bank X and a read freeing bank Y on the same edge are both honoured.
  - A read may start on a bank the same edge after its full flag sets. There is no bubble between consecutive blocks.
- Backpressure: when both banks are full, in_ready=0. in_ready returns to 1 the cycle after the read side frees a bank.
- Held output: out_byte and out_last stay stable while out_valid=1 and out_ready=0.
- in_byte is ignored while in_valid=0 or in_ready=0.

Optional Feature:
- Macro: SHIFT_ROWS_INV_EN.
- When defined:
  - Adds input port inverse (1 bit). It is sampled with byte 0 of each block on the read side, i.e. when rd_cnt=0 loads, and held for the whole block.
  - inverse=1 selects the address 4*((c - r) & 3) + r, which is InvShiftRows.
- When not defined: the port is absent and the permutation is forward-only.

Decomposition:
- Shared package aes_pkg holds:
  - BLOCK_BYTES=16 and BYTE_W=8.
  - The row/column index helpers.
  - The bank-state enum {IDLE, STREAM}.
- Sub-module shift_rows_addr: combinational mapping (rd_cnt[3:0], inverse) -> bank address [3:0]. It is reusable by the inverse-side block.

Test Plan:
- Ramp: bytes 00..0f with out_ready=1 -> output 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b; out_last on 0b; first out_valid one cycle after byte 0f is accepted.
- FIPS-197 App. B round 1: input d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> output d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
- Back-to-back: three blocks streamed continuously with out_ready=1 -> 48 output bytes with no gap between blocks; in_ready constantly 1.
- Backpressure: out_ready=0 while two blocks are written -> in_ready=0 after byte 31; out_byte held at 00; releasing out_ready drains both blocks correctly.
- Reset: assert reset after 7 bytes of a block -> out_valid=0 and in_ready=1 after deassert; the next full block outputs correctly with no residue.
- With SHIFT_ROWS_INV_EN: inverse=1 on the ramp -> 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03; a forward-then-inverse loopback returns the original block.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte-stream constants, state index helpers and bank-state enum
package aes_pkg;
  localparam int BLOCK_BYTES = 16;
  localparam int BYTE_W = 8;
  typedef enum logic {IDLE, STREAM} bank_state_e;
  function automatic logic [1:0] row_of(input logic [3:0] k);
    return k[1:0];
  endfunction
  function automatic logic [1:0] col_of(input logic [3:0] k);
    return k[3:2];
  endfunction
endpackage

// File: rtl/shift_rows_addr.sv
// shift_rows_addr: output index k=4c+r -> bank address of (Inv)ShiftRows source byte
module shift_rows_addr
  import aes_pkg::*;
(
  input  logic [3:0] idx,
  input  logic       inverse,
  output logic [3:0] addr
);
  logic [1:0] r, c;
  // Column offset by row, wrapping mod 4; row is unchanged.
  always_comb begin
    r = row_of(idx);
    c = col_of(idx);
    addr = {inverse ? c - r : c + r, r};
  end
endmodule

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: byte-serial AES ShiftRows over a 2-bank ping-pong buffer; SHIFT_ROWS_INV_EN adds per-block InvShiftRows select
module shift_rows_stream
  import aes_pkg::*;
#(
  parameter int DATA_W = BYTE_W
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SHIFT_ROWS_INV_EN
  input  logic              inverse,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_byte,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_byte,
  input  logic              out_ready,
  output logic              out_last
);
  logic [DATA_W-1:0] bank_mem [2][BLOCK_BYTES];
  logic [3:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, rd_addr;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DATA_W-1:0] out_byte_q, out_byte_d;
  bank_state_e state_q, state_d;
  logic wr_en, wr_done, ld, rd_done, inv_sel;
`ifdef SHIFT_ROWS_INV_EN
  logic inv_q, inv_d;
  // Direction is latched with byte 0 of a block and held until it drains.
  always_comb begin
    inv_sel = (rd_cnt_q == 4'd0) ? inverse : inv_q;
    inv_d = ld ? inv_sel : inv_q;
  end
  // Direction register.
  always_ff @(posedge clock or posedge reset)
    if (reset) inv_q <= 1'b0;
    else inv_q <= inv_d;
`else
  assign inv_sel = 1'b0;
`endif
  shift_rows_addr u_addr (
    .idx    (rd_cnt_q),
    .inverse(inv_sel),
    .addr   (rd_addr)
  );
  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_last  = out_last_q;
  // Write/read pointers, bank full flags and the output register advance.
  always_comb begin
    wr_en = in_valid & ~full_q[wr_bank_q];
    wr_done = wr_en & (wr_cnt_q == 4'd15);
    ld = (~out_valid_q | out_ready) & full_q[rd_bank_q];
    rd_done = ld & (rd_cnt_q == 4'd15);
    wr_cnt_d = wr_en ? wr_cnt_q + 4'd1 : wr_cnt_q;
    wr_bank_d = wr_bank_q ^ wr_done;
    rd_cnt_d = ld ? rd_cnt_q + 4'd1 : rd_cnt_q;
    rd_bank_d = rd_bank_q ^ rd_done;
    full_d = full_q;
    if (rd_done) full_d[rd_bank_q] = 1'b0;
    if (wr_done) full_d[wr_bank_q] = 1'b1;
    out_valid_d = ld | (out_valid_q & ~out_ready);
    out_byte_d = ld ? bank_mem[rd_bank_q][rd_addr] : out_byte_q;
    out_last_d = ld ? rd_done : out_last_q;
    state_d = ld ? (rd_done ? IDLE : STREAM) : state_q;
  end
  // Control state; bank contents are deliberately left unreset.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q <= '0;
      out_valid_q <= 1'b0;
      out_byte_q <= '0;
      out_last_q <= 1'b0;
      state_q <= IDLE;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q <= full_d;
      out_valid_q <= out_valid_d;
      out_byte_q <= out_byte_d;
      out_last_q <= out_last_d;
      state_q <= state_d;
    end
  // Bank storage write port.
  always_ff @(posedge clock)
    if (wr_en) bank_mem[wr_bank_q][wr_cnt_q] <= in_byte;
endmodule
